// File: rtl/lcd_nibble_writer_pkg.sv
// Shared state encoding, LCD command codes and the init/config constant tables
// for the 4-bit character-LCD write engine.
package lcd_nibble_writer_pkg;

  typedef enum logic [3:0] {
    S_POWERON,
    S_INIT_NIB,
    S_INIT_E,
    S_INIT_HOLD,
    S_INIT_WAIT,
    S_CFG,
    S_LATCH,
    S_SETUP_HI,
    S_E_HI,
    S_HOLD_HI,
    S_GAP,
    S_SETUP_LO,
    S_E_LO,
    S_HOLD_LO,
    S_SETTLE,
    S_IDLE
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // Function set 4-bit/2-line, entry mode inc, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed state; done while the count is zero.
module lcd_delay_timer #(
  parameter int unsigned             WIDTH       = 20,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= RESET_VALUE;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus write engine: autonomous power-on init/config, then byte
// writes accepted through a valid/ready handshake.
module lcd_nibble_writer
  import lcd_nibble_writer_pkg::*;
#(
  parameter int unsigned P_POWERON_WAIT = 750000,
  parameter int unsigned P_INIT_WAIT1   = 205000,
  parameter int unsigned P_INIT_WAIT2   = 5000,
  parameter int unsigned P_CMD_WAIT     = 2000,
  parameter int unsigned P_CLEAR_WAIT   = 82000,
  parameter int unsigned P_E_PULSE      = 12,
  parameter int unsigned P_NIBBLE_GAP   = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  // Timer is loaded with (state length - 1); a state ends on the edge where it reads zero.
  localparam logic [19:0] L_ONE   = '0;
  localparam logic [19:0] L_SETUP = 20'd1;
  localparam logic [19:0] L_E     = 20'(P_E_PULSE - 1);
  localparam logic [19:0] L_GAP   = 20'(P_NIBBLE_GAP - 1);
  localparam logic [19:0] L_W1    = 20'(P_INIT_WAIT1 - 1);
  localparam logic [19:0] L_W2    = 20'(P_INIT_WAIT2 - 1);
  localparam logic [19:0] L_CMD   = 20'(P_CMD_WAIT - 1);
  localparam logic [19:0] L_CLR   = 20'(P_CLEAR_WAIT - 1);

  state_t      state, nxt;
  logic [19:0] nxt_len;
  logic [1:0]  idx, idx_next;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        tmr_done, advance, is_clear, bump;

  assign oLCD_RW  = 1'b0;
  assign advance  = (state == S_IDLE) ? (iValid && oReady) : tmr_done;
  assign is_clear = !rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME);
  // One index walks the four init nibbles, wraps, then walks the four config bytes.
  assign bump     = (state == S_INIT_WAIT) || (state == S_SETTLE && !oInitDone);
  assign idx_next = bump ? idx + 2'd1 : idx;

  always_comb begin
    nxt     = state;
    nxt_len = L_ONE;
    case (state)
      S_POWERON:   begin nxt = S_INIT_NIB;  nxt_len = L_SETUP; end
      S_INIT_NIB:  begin nxt = S_INIT_E;    nxt_len = L_E;     end
      S_INIT_E:    begin nxt = S_INIT_HOLD; nxt_len = L_ONE;   end
      S_INIT_HOLD: begin
        nxt = S_INIT_WAIT;
        case (idx)
          2'd0:    nxt_len = L_W1;
          2'd1:    nxt_len = L_W2;
          default: nxt_len = L_CMD;
        endcase
      end
      S_INIT_WAIT: begin
        if (idx == 2'd3) begin
          nxt = S_CFG;      nxt_len = L_ONE;
        end else begin
          nxt = S_INIT_NIB; nxt_len = L_SETUP;
        end
      end
      S_CFG, S_LATCH: begin nxt = S_SETUP_HI; nxt_len = L_SETUP; end
      S_SETUP_HI:  begin nxt = S_E_HI;     nxt_len = L_E;     end
      S_E_HI:      begin nxt = S_HOLD_HI;  nxt_len = L_ONE;   end
      S_HOLD_HI:   begin nxt = S_GAP;      nxt_len = L_GAP;   end
      S_GAP:       begin nxt = S_SETUP_LO; nxt_len = L_SETUP; end
      S_SETUP_LO:  begin nxt = S_E_LO;     nxt_len = L_E;     end
      S_E_LO:      begin nxt = S_HOLD_LO;  nxt_len = L_ONE;   end
      S_HOLD_LO:   begin nxt = S_SETTLE;   nxt_len = is_clear ? L_CLR : L_CMD; end
      S_SETTLE:    nxt = (!oInitDone && idx != 2'd3) ? S_CFG : S_IDLE;
      S_IDLE:      nxt = S_LATCH;
      default:     nxt = S_POWERON;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_POWERON;
      idx       <= '0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      oReady    <= 1'b0;
      oInitDone <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= '0;
    end else if (advance) begin
      state <= nxt;
      idx   <= idx_next;
      // Outputs are set on entry to the next state so they are all registered.
      case (nxt)
        S_INIT_NIB: begin
          oLCD_Data <= init_nibble(idx_next);
          oLCD_RS   <= 1'b0;
        end
        S_CFG: begin
          byte_q <= cfg_byte(idx_next);
          rs_q   <= 1'b0;
        end
        S_LATCH: begin
          byte_q <= iData;
          rs_q   <= iRS;
          oReady <= 1'b0;
        end
        S_INIT_E, S_E_HI, S_E_LO:          oLCD_E <= 1'b1;
        S_INIT_HOLD, S_HOLD_HI, S_HOLD_LO: oLCD_E <= 1'b0;
        S_SETUP_HI: begin
          oLCD_Data <= byte_q[7:4];
          oLCD_RS   <= rs_q;
        end
        S_SETUP_LO: oLCD_Data <= byte_q[3:0];
        S_IDLE: begin
          oReady    <= 1'b1;
          oInitDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  lcd_delay_timer #(
    .WIDTH      (20),
    .RESET_VALUE(20'(P_POWERON_WAIT))
  ) u_timer (
    .Clock(Clock),
    .Reset(Reset),
    .load (advance),
    .value(nxt_len),
    .done (tmr_done)
  );

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with scaled delays: checks init sequence
// timing, byte writes, settle lengths, handshake behaviour and mid-transfer reset.
module tb_lcd_nibble_writer;

  localparam int PW = 10, W1 = 8, W2 = 6, CMD = 4, CLR = 12, PE = 3, GAP = 5;
  // Accept edge to ready edge, excluding the settle time.
  localparam int BASE = 1 + 2 + PE + 1 + GAP + 2 + PE + 1;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] din = '0;
  logic       rs_in = 1'b0, valid = 1'b0;
  logic       ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  int         ev_rise[$], ev_width[$];
  logic [3:0] ev_data[$];
  logic       ev_rs[$];
  int         ready_rise = -1, done_rise = -1;

  lcd_nibble_writer #(
    .P_POWERON_WAIT(PW), .P_INIT_WAIT1(W1), .P_INIT_WAIT2(W2), .P_CMD_WAIT(CMD),
    .P_CLEAR_WAIT(CLR), .P_E_PULSE(PE), .P_NIBBLE_GAP(GAP)
  ) dut (
    .Clock(clk), .Reset(rst), .iData(din), .iRS(rs_in), .iValid(valid),
    .oReady(ready), .oInitDone(init_done), .oLCD_E(lcd_e), .oLCD_RS(lcd_rs),
    .oLCD_RW(lcd_rw), .oLCD_Data(lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  // Bus monitor: records each E pulse and checks Data/RS stability and RW.
  logic       e_p = 1'b0, rs_p = 1'b0, rdy_p = 1'b0, dn_p = 1'b0;
  logic [3:0] d_p = '0, rise_d = '0;
  logic       rise_rs = 1'b0;
  int         rise_c = 0;

  always @(negedge clk) begin
    n_checks++;
    if (lcd_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_low: cycle %0d got %b expected 0", cyc, lcd_rw);
    end
    if (!rst_q) begin
      if (lcd_e && !e_p) begin
        rise_c = cyc; rise_d = lcd_data; rise_rs = lcd_rs;
      end
      if (!lcd_e && e_p) begin
        ev_rise.push_back(rise_c); ev_width.push_back(cyc - rise_c);
        ev_data.push_back(rise_d); ev_rs.push_back(rise_rs);
      end
      if (lcd_e || e_p) begin
        n_checks++;
        if (lcd_data !== d_p || lcd_rs !== rs_p) begin
          n_fail++;
          $display("FAIL bus_stable: cycle %0d got data=%h rs=%b expected data=%h rs=%b",
                   cyc, lcd_data, lcd_rs, d_p, rs_p);
        end
      end
      if (ready && !rdy_p) ready_rise = cyc;
      if (init_done && !dn_p) done_rise = cyc;
    end
    e_p = lcd_e; d_p = lcd_data; rs_p = lcd_rs; rdy_p = ready; dn_p = init_done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_rise.delete(); ev_width.delete(); ev_data.delete(); ev_rs.delete();
    ready_rise = -1; done_rise = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r, output int acc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready) begin ok = 1'b1; break; end
      tick();
    end
    din = b; rs_in = r; valid = 1'b1;
    acc = cyc + 1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !ready; i++) tick();
    n_checks++;
    if (!ready) begin
      n_fail++;
      $display("FAIL %s_timeout: got ready=%b expected 1 within 300 cycles", tag, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%b init_done=%b expected 0 0", ready, init_done);
    end
    n_checks++;
    if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got e=%b rs=%b data=%h expected 0 0 0", lcd_e, lcd_rs, lcd_data);
    end
  endtask

  task automatic test_init(input string tag);
    int rel, exp_ready;
    int exp_r[12];
    int w[4];
    logic [3:0] exp_d[12];
    exp_d = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    w = '{W1, W2, CMD, CMD};
    clear_events();
    rst = 1'b0;
    rel = cyc + 1;
    exp_r[0] = rel + PW + 2;
    for (int i = 1; i < 4; i++) exp_r[i] = exp_r[i-1] + PE + 1 + w[i-1] + 2;
    exp_r[4] = exp_r[3] + PE + 1 + CMD + 1 + 2;
    for (int b = 0; b < 4; b++) begin
      exp_r[5+2*b] = exp_r[4+2*b] + PE + 1 + GAP + 2;
      if (b < 3) exp_r[6+2*b] = exp_r[5+2*b] + PE + 1 + CMD + 1 + 2;
    end
    exp_ready = exp_r[11] + PE + 1 + CLR;
    for (int i = 0; i < 2000 && !init_done; i++) tick();
    n_checks++;
    if (!init_done) begin
      n_fail++;
      $display("FAIL %s_timeout: got init_done=%b expected 1", tag, init_done);
    end
    n_checks++;
    if (ev_rise.size() != 12) begin
      n_fail++;
      $display("FAIL %s_pulse_count: got %0d expected 12", tag, ev_rise.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (ev_data[i] !== exp_d[i] || ev_rs[i] !== 1'b0 || ev_rise[i] != exp_r[i] || ev_width[i] != PE) begin
          n_fail++;
          $display("FAIL %s_pulse%0d: got data=%h rs=%b rise=%0d width=%0d expected data=%h rs=0 rise=%0d width=%0d",
                   tag, i, ev_data[i], ev_rs[i], ev_rise[i], ev_width[i], exp_d[i], exp_r[i], PE);
        end
      end
    end
    n_checks++;
    if (ready_rise != exp_ready || done_rise != exp_ready) begin
      n_fail++;
      $display("FAIL %s_done_time: got ready_rise=%0d done_rise=%0d expected %0d",
               tag, ready_rise, done_rise, exp_ready);
    end
  endtask

  task automatic test_data_write();
    int acc;
    bit ok;
    clear_events();
    send_byte(8'h41, 1'b1, acc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL data_accept: got ready=0 expected 1"); end
    wait_ready("data");
    n_checks++;
    if (ev_rise.size() != 2) begin
      n_fail++;
      $display("FAIL data_pulse_count: got %0d expected 2", ev_rise.size());
    end else begin
      n_checks++;
      if (ev_data[0] !== 4'h4 || ev_data[1] !== 4'h1 || ev_rs[0] !== 1'b1 || ev_rs[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL data_nibbles: got %h/%b %h/%b expected 4/1 1/1", ev_data[0], ev_rs[0], ev_data[1], ev_rs[1]);
      end
      n_checks++;
      if (ev_width[0] != PE || ev_width[1] != PE) begin
        n_fail++;
        $display("FAIL data_e_width: got %0d %0d expected %0d", ev_width[0], ev_width[1], PE);
      end
      n_checks++;
      if (ev_rise[0] != acc + 3 || ev_rise[1] != acc + 3 + PE + 1 + GAP + 2) begin
        n_fail++;
        $display("FAIL data_e_rise: got %0d %0d expected %0d %0d",
                 ev_rise[0], ev_rise[1], acc + 3, acc + 3 + PE + 1 + GAP + 2);
      end
    end
    n_checks++;
    if (ready_rise != acc + BASE + CMD) begin
      n_fail++;
      $display("FAIL data_ready_time: got %0d expected %0d", ready_rise, acc + BASE + CMD);
    end
  endtask

  task automatic test_settle();
    logic [7:0] tb_b[4];
    logic       tb_r[4];
    int         tb_s[4];
    int acc;
    bit ok;
    tb_b = '{8'h01, 8'h80, 8'h02, 8'h01};
    tb_r = '{1'b0, 1'b0, 1'b0, 1'b1};
    tb_s = '{CLR, CMD, CLR, CMD};
    for (int i = 0; i < 4; i++) begin
      clear_events();
      send_byte(tb_b[i], tb_r[i], acc, ok);
      wait_ready("settle");
      n_checks++;
      if (!ok || ready_rise != acc + BASE + tb_s[i]) begin
        n_fail++;
        $display("FAIL settle_%h_rs%b: got ready_rise=%0d expected %0d",
                 tb_b[i], tb_r[i], ready_rise, acc + BASE + tb_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc2;
    clear_events();
    wait_ready("b2b_pre");
    din = 8'h55; rs_in = 1'b1; valid = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (ready) break;
      din = 8'hA0 + 8'(k);
    end
    din = 8'h3C;
    acc2 = cyc + 1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (acc2 != acc + BASE + CMD + 1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got %0d expected %0d", acc2, acc + BASE + CMD + 1);
    end
    wait_ready("b2b");
    n_checks++;
    if (ev_rise.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d expected 4", ev_rise.size());
    end else begin
      n_checks++;
      if ({ev_data[0], ev_data[1], ev_data[2], ev_data[3]} !== 16'h553C) begin
        n_fail++;
        $display("FAIL b2b_nibbles: got %h%h%h%h expected 553c", ev_data[0], ev_data[1], ev_data[2], ev_data[3]);
      end
      n_checks++;
      if (ev_rise[2] != acc2 + 3) begin
        n_fail++;
        $display("FAIL b2b_second_rise: got %0d expected %0d", ev_rise[2], acc2 + 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    clear_events();
    send_byte(8'h41, 1'b1, acc, ok);
    for (int i = 0; i < 300 && !(ev_rise.size() == 1 && lcd_e); i++) tick();
    n_checks++;
    if (!(ev_rise.size() == 1 && lcd_e)) begin
      n_fail++;
      $display("FAIL rstmid_reach_e_lo: got pulses=%0d e=%b expected 1 1", ev_rise.size(), lcd_e);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (lcd_e !== 1'b0 || lcd_data !== 4'h0 || ready !== 1'b0 || init_done !== 1'b0 || lcd_rs !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got e=%b data=%h ready=%b done=%b rs=%b expected all 0",
               lcd_e, lcd_data, ready, init_done, lcd_rs);
    end
    repeat (2) tick();
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_data_write();
    test_settle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time %0t expected completion earlier", $time);
    $fatal(1);
  end

endmodule
